// File: rtl/freq_scheduler_if.sv
// Keyboard-side note handshake into the frequency scheduler.
// Latency: none, wires only.
// Backpressure: key_ready low means a key_valid strobe is discarded, not held.
interface freq_scheduler_if;
    logic       key_valid;
    logic [4:0] key_id1;
    logic [4:0] key_id2;
    logic       key_ready;

    modport master (output key_valid, key_id1, key_id2, input key_ready);
    modport slave  (input key_valid, key_id1, key_id2, output key_ready);
endinterface

// File: rtl/freq_scheduler.sv
// Sequences normalised, de-duplicated note pairs into the physics frequency inputs with vsync-frame holdoff.
// Latency: key strobe to new_f_in pulse is 2 clocks when idle; then HOLD_FRAMES vsync falls before the next.
// Backpressure: key_ready drops when the queue is full or a restart is in progress; strobes then pulse dropped.
module freq_scheduler #(
    parameter int DEPTH       = 4,
    parameter int LOG         = 2,
    parameter int HOLD_FRAMES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vsync,
    input  logic             restart,
    freq_scheduler_if.slave  key,
    output logic [4:0]       freq_id1,
    output logic [4:0]       freq_id2,
    output logic             new_f_in,
    output logic             r_offset,
    output logic             busy,
    output logic [LOG:0]     fifo_count,
    output logic             dropped
);
    typedef enum logic [2:0] {IDLE, ISSUE, HOLD, RESTART, FLAT} state_t;

    localparam logic [LOG:0] DEPTH_C = (LOG + 1)'(DEPTH);
    localparam logic [9:0]   NONE_PAIR = {5'd31, 5'd31};

    state_t         state, state_nxt;
    logic [2:0]     vs_sync;
    logic           vsync_fall;
    logic [3:0]     hold_cnt;
    logic           restart_pend, restart_any, enter_restart;
    logic [9:0]     norm_pair, last_pair;
    logic           dup, ready, push, pop, drop_now;
    logic [LOG-1:0] wr_ptr, rd_ptr;
    logic [9:0]     mem [DEPTH];

    // Map out-of-range ids to "none" and keep a lone note in the first slot.
    function automatic logic [9:0] normalise(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] x, y;
        x = (a >= 5'd25) ? 5'd31 : a;
        y = (b >= 5'd25) ? 5'd31 : b;
        if (x == 5'd31 && y != 5'd31) return {y, x};
        return {x, y};
    endfunction

    assign vsync_fall  = vs_sync[2] & ~vs_sync[1];
    assign restart_any = restart | restart_pend;
    assign norm_pair   = normalise(key.key_id1, key.key_id2);
    assign dup         = (norm_pair == last_pair);
    assign ready       = (fifo_count < DEPTH_C) && (state != RESTART);
    assign key.key_ready = ready;
    assign enter_restart = (state_nxt == RESTART) && (state != RESTART);
    assign push        = key.key_valid & ready & ~enter_restart & ~dup;
    assign drop_now    = key.key_valid & (~ready | enter_restart);
    assign new_f_in    = (state == ISSUE) || (state == FLAT);
    assign busy        = (state != IDLE);

    // Two-flop vsync synchroniser plus one history flop for the falling-edge detect; idles high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) vs_sync <= 3'b111;
        else        vs_sync <= {vs_sync[1:0], vsync};
    end

    // Next-state decode; restart wins over queued work and aborts a holdoff.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (restart_any)          state_nxt = RESTART;
                else if (fifo_count != 0) state_nxt = ISSUE;
            end
            ISSUE: begin
                pop       = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (restart_any)                         state_nxt = RESTART;
                else if (vsync_fall && hold_cnt <= 4'd1) state_nxt = IDLE;
            end
            RESTART: begin
                if (vsync_fall && hold_cnt <= 4'd1) state_nxt = FLAT;
            end
            FLAT:    state_nxt = HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers: state, frame counter, restart latch and the physics-facing outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            hold_cnt     <= 4'd0;
            restart_pend <= 1'b0;
            r_offset     <= 1'b0;
            freq_id1     <= 5'd31;
            freq_id2     <= 5'd31;
            dropped      <= 1'b0;
            last_pair    <= NONE_PAIR;
        end else begin
            state   <= state_nxt;
            dropped <= drop_now;

            // A strobe seen while issuing is remembered until HOLD can act on it.
            if (enter_restart || state == RESTART) restart_pend <= 1'b0;
            else if (restart)                      restart_pend <= 1'b1;

            // The same counter times the holdoff and the two-frame offset reset.
            if (enter_restart)                             hold_cnt <= 4'd2;
            else if (state == ISSUE || state == FLAT)      hold_cnt <= 4'(HOLD_FRAMES);
            else if ((state == HOLD || state == RESTART) && vsync_fall && hold_cnt != 4'd0)
                hold_cnt <= hold_cnt - 4'd1;

            if (enter_restart)                                 r_offset <= 1'b1;
            else if (state == RESTART && state_nxt == FLAT)    r_offset <= 1'b0;

            if (state == IDLE && state_nxt == ISSUE) begin
                {freq_id1, freq_id2} <= mem[rd_ptr];
            end else if (state == RESTART && state_nxt == FLAT) begin
                freq_id1 <= 5'd31;
                freq_id2 <= 5'd31;
            end

            if (enter_restart) last_pair <= NONE_PAIR;
            else if (push)     last_pair <= norm_pair;
        end
    end

    // Queue pointers and occupancy; a restart flushes everything in one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (enter_restart) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= norm_pair;
    end
endmodule

// File: tb/tb_freq_scheduler.sv
// Directed stimulus against a queue scoreboard of expected frequency pairs.
// Latency: expected pairs are popped whenever new_f_in is seen at a falling clock edge.
// Backpressure: the bench models queue occupancy, dedup and restart to predict drops.
module tb_freq_scheduler;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       vsync = 1'b1;
    logic       restart = 1'b0;
    logic [4:0] freq_id1, freq_id2;
    logic       new_f_in, r_offset, busy, dropped;
    logic [2:0] fifo_count;

    freq_scheduler_if kif();

    freq_scheduler #(.DEPTH(4), .LOG(2), .HOLD_FRAMES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .vsync      (vsync),
        .restart    (restart),
        .key        (kif.slave),
        .freq_id1   (freq_id1),
        .freq_id2   (freq_id2),
        .new_f_in   (new_f_in),
        .r_offset   (r_offset),
        .busy       (busy),
        .fifo_count (fifo_count),
        .dropped    (dropped)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    int         issue_cnt = 0;
    int         base;
    logic [9:0] exp_q [$];
    logic [9:0] mdl_last;
    bit         mdl_restart = 1'b0;
    bit         prev_nf = 1'b0;
    logic [9:0] exp_pair;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] norm(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] x, y;
        x = (a > 5'd24) ? 5'd31 : a;
        y = (b > 5'd24) ? 5'd31 : b;
        if (x == 5'd31 && y != 5'd31) return {y, x};
        return {x, y};
    endfunction

    // Scoreboard side: every new_f_in pulse must match the oldest expected pair.
    always @(negedge clock) begin
        if (!reset) begin
            prev_nf = 1'b0;
        end else begin
            if (new_f_in) begin
                check("nf_not_back_to_back", 32'(prev_nf), 32'd0);
                check("issue_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_pair = exp_q.pop_front();
                    check("issue_pair", 32'({freq_id1, freq_id2}), 32'(exp_pair));
                end
                issue_cnt++;
            end
            prev_nf = new_f_in;
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic vs_pulse;
        vsync = 1'b0;
        repeat (4) tick();
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic model_restart;
        exp_q.delete();
        exp_q.push_back({5'd31, 5'd31});
        mdl_last    = {5'd31, 5'd31};
        mdl_restart = 1'b1;
    endtask

    task automatic send_key(input logic [4:0] a, input logic [4:0] b);
        logic [9:0] n;
        bit         drop, dup;
        n    = norm(a, b);
        drop = mdl_restart || (exp_q.size() >= 4) || restart;
        dup  = (n == mdl_last);
        if (!drop && !dup) begin
            exp_q.push_back(n);
            mdl_last = n;
        end
        kif.key_valid = 1'b1;
        kif.key_id1   = a;
        kif.key_id2   = b;
        tick();
        kif.key_valid = 1'b0;
        check("dropped", 32'(dropped), 32'(drop));
    endtask

    task automatic do_restart;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        model_restart();
        check("restart_roff", 32'(r_offset), 32'd1);
        check("restart_flush", 32'(fifo_count), 32'd0);
    endtask

    // Walks the two-frame offset window and checks the flat-wave issue timing.
    task automatic finish_restart;
        vs_pulse();
        check("roff_after_fall1", 32'(r_offset), 32'd1);
        vsync = 1'b0;
        tick();
        tick();
        check("roff_in_fall2_cycle", 32'(r_offset), 32'd1);
        tick();
        check("roff_cleared", 32'(r_offset), 32'd0);
        check("flat_nf", 32'(new_f_in), 32'd1);
        mdl_restart = 1'b0;
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        kif.key_valid = 1'b0;
        kif.key_id1   = 5'd0;
        kif.key_id2   = 5'd0;
        mdl_last      = {5'd31, 5'd31};
        repeat (3) tick();
        check("rst_freq1", 32'(freq_id1), 32'd31);
        reset = 1'b1;
        tick();

        check("rst_freq1", 32'(freq_id1), 32'd31);
        check("rst_freq2", 32'(freq_id2), 32'd31);
        check("rst_nf", 32'(new_f_in), 32'd0);
        check("rst_roff", 32'(r_offset), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(kif.key_ready), 32'd1);
        check("rst_dropped", 32'(dropped), 32'd0);

        // Single key: pulse two clocks after the strobe, busy through two frames.
        send_key(5'd3, 5'd7);
        check("t1_no_early_nf", 32'(new_f_in), 32'd0);
        tick();
        check("t1_nf", 32'(new_f_in), 32'd1);
        check("t1_freq1", 32'(freq_id1), 32'd3);
        check("t1_freq2", 32'(freq_id2), 32'd7);
        tick();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_count", 32'(fifo_count), 32'd0);
        vs_pulse();
        check("t1_busy_after1", 32'(busy), 32'd1);
        vs_pulse();
        check("t1_idle_after2", 32'(busy), 32'd0);

        // Overfill while holding, then drain at two frames per issue.
        send_key(5'd1, 5'd2);
        repeat (4) tick();
        send_key(5'd4, 5'd5);
        send_key(5'd6, 5'd7);
        send_key(5'd8, 5'd9);
        send_key(5'd10, 5'd11);
        send_key(5'd12, 5'd13);
        check("t2_count_full", 32'(fifo_count), 32'(exp_q.size()));
        check("t2_ready_full", 32'(kif.key_ready), 32'(exp_q.size() < 4));
        for (int i = 0; i < 4; i++) begin
            base = issue_cnt;
            vs_pulse();
            check("t2_no_issue_after1", 32'(issue_cnt), 32'(base));
            vs_pulse();
            check("t2_issue_after2", 32'(issue_cnt), 32'(base + 1));
        end
        vs_pulse();
        vs_pulse();
        check("t2_drained", 32'(exp_q.size()), 32'd0);
        check("t2_idle", 32'(busy), 32'd0);

        // Normalisation and dedup.
        send_key(5'd31, 5'd12);
        repeat (4) tick();
        send_key(5'd27, 5'd5);
        check("t3_count", 32'(fifo_count), 32'd1);
        send_key(5'd5, 5'd31);
        check("t3_dup_count", 32'(fifo_count), 32'(exp_q.size()));
        vs_pulse();
        vs_pulse();
        vs_pulse();
        vs_pulse();
        check("t3_idle", 32'(busy), 32'd0);

        // Restart during holdoff with two queued pairs.
        send_key(5'd20, 5'd21);
        repeat (4) tick();
        send_key(5'd22, 5'd23);
        send_key(5'd24, 5'd0);
        check("t4_count", 32'(fifo_count), 32'd2);
        do_restart();
        finish_restart();
        vs_pulse();
        vs_pulse();
        check("t4_idle", 32'(busy), 32'd0);

        // Restart and key in the same cycle; afterwards the none-pair is a duplicate.
        send_key(5'd6, 5'd6);
        repeat (4) tick();
        restart = 1'b1;
        send_key(5'd9, 5'd9);
        restart = 1'b0;
        model_restart();
        check("t5_roff", 32'(r_offset), 32'd1);
        check("t5_flush", 32'(fifo_count), 32'd0);
        finish_restart();
        vs_pulse();
        vs_pulse();
        send_key(5'd31, 5'd31);
        check("t5_dup_count", 32'(fifo_count), 32'd0);
        repeat (6) tick();
        check("t5_idle", 32'(busy), 32'd0);

        // Asynchronous reset while the offset reset is in progress.
        send_key(5'd2, 5'd3);
        repeat (4) tick();
        vs_pulse();
        vs_pulse();
        do_restart();
        #2;
        reset = 1'b0;
        #1;
        check("t6_roff", 32'(r_offset), 32'd0);
        check("t6_freq1", 32'(freq_id1), 32'd31);
        check("t6_freq2", 32'(freq_id2), 32'd31);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_nf", 32'(new_f_in), 32'd0);
        exp_q.delete();
        mdl_restart = 1'b0;
        mdl_last    = {5'd31, 5'd31};
        tick();
        reset = 1'b1;
        base = issue_cnt;
        vs_pulse();
        vs_pulse();
        repeat (5) tick();
        check("t6_no_issue", 32'(issue_cnt), 32'(base));
        check("t6_count", 32'(fifo_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
